regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer_if.sv | 23 ++
 rtl/regfile_sequencer.sv | 176 +++++++++++++++++
 tb/tb_regfile_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// Command/response handshake bundle for regfile_sequencer.
// The master issues commands and consumes responses; the slave is the sequencer.
interface regfile_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [3:0] cmd_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_data;
  logic       resp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, resp_ready,
    input  cmd_ready, resp_valid, resp_data, resp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, resp_ready,
    output cmd_ready, resp_valid, resp_data, resp_carry
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Sequences READ/WRITE/ADD/CLEAR commands onto an external 4x4 regfile that
// writes every cycle; idle cycles rewrite the addressed entry with its own value.
module regfile_sequencer (
  input  logic                       CLK,
  input  logic                       RESET,
  regfile_sequencer_if.slave         bus,
  output logic                       busy,
  output logic [1:0]                 rf_read_addr,
  input  logic [3:0]                 rf_read_data,
  output logic [1:0]                 rf_write_addr,
  output logic [3:0]                 rf_write_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SWEEP = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ADD   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic [1:0] ptr_q, ptr_d;
  logic       respond_q, respond_d;
  logic [3:0] resp_data_q, resp_data_d;
  logic       resp_carry_q, resp_carry_d;
  logic       busy_q;
  logic       cmd_ready_q;
  logic       resp_valid_q;
  logic [4:0] sum_s;

  assign sum_s          = {1'b0, rf_read_data} + {1'b0, data_q};
  assign busy           = busy_q;
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_carry = resp_carry_q;

  // Read-port address selection by state.
  always_comb begin
    rf_read_addr = 2'd0;
    case (state_q)
      EXEC:    rf_read_addr = addr_q;
      SWEEP:   rf_read_addr = ptr_q;
      IDLE:    rf_read_addr = 2'd0;
      RESP:    rf_read_addr = 2'd0;
      default: rf_read_addr = 2'd0;
    endcase
  end

  // Next-state, latched-command, response and regfile write-port logic.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    ptr_d         = ptr_q;
    respond_d     = respond_q;
    resp_data_d   = resp_data_q;
    resp_carry_d  = resp_carry_q;
    rf_write_addr = rf_read_addr;
    rf_write_data = rf_read_data;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          addr_d = bus.cmd_addr;
          data_d = bus.cmd_data;
          if (bus.cmd_op == OP_CLEAR) begin
            state_d   = SWEEP;
            ptr_d     = 2'd0;
            respond_d = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      EXEC: begin
        state_d = RESP;
        case (op_q)
          OP_READ: begin
            resp_data_d  = rf_read_data;
            resp_carry_d = 1'b0;
          end
          OP_WRITE: begin
            rf_write_data = data_q;
            resp_data_d   = data_q;
            resp_carry_d  = 1'b0;
          end
          OP_ADD: begin
            rf_write_data = sum_s[3:0];
            resp_data_d   = sum_s[3:0];
            resp_carry_d  = sum_s[4];
          end
          default: begin
            resp_data_d  = 4'd0;
            resp_carry_d = 1'b0;
          end
        endcase
      end

      SWEEP: begin
        rf_write_data = 4'd0;
        ptr_d         = ptr_q + 2'd1;
        if (ptr_q == 2'd3) begin
          respond_d = 1'b0;
          if (respond_q) begin
            state_d      = RESP;
            resp_data_d  = 4'd0;
            resp_carry_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SWEEP;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d   = SWEEP;
        ptr_d     = 2'd0;
        respond_d = 1'b0;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= SWEEP;
      op_q         <= 2'd0;
      addr_q       <= 2'd0;
      data_q       <= 4'd0;
      ptr_q        <= 2'd0;
      respond_q    <= 1'b0;
      resp_data_q  <= 4'd0;
      resp_carry_q <= 1'b0;
      busy_q       <= 1'b1;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ptr_q        <= ptr_d;
      respond_q    <= respond_d;
      resp_data_q  <= resp_data_d;
      resp_carry_q <= resp_carry_d;
      busy_q       <= (state_d != IDLE);
      cmd_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: directed vector table, hand-written
// stall/reset sequences, and random commands against an array-based model.
module tb_regfile_sequencer;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ADD   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef struct {
    logic [1:0] op;
    logic [1:0] addr;
    logic [3:0] data;
    logic [3:0] exp_data;
    logic       exp_carry;
    int         exp_lat;
  } vec_t;

  logic       CLK;
  logic       RESET;
  logic       busy;
  logic [1:0] rf_read_addr;
  logic [3:0] rf_read_data;
  logic [1:0] rf_write_addr;
  logic [3:0] rf_write_data;

  logic [3:0] rf_mem [4];
  logic [3:0] ref_mem [4];

  int n_tests;
  int n_fail;

  regfile_sequencer_if bus ();

  regfile_sequencer dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .bus           (bus),
    .busy          (busy),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data)
  );

  // External regfile: combinational read, unconditional write every cycle.
  assign rf_read_data = rf_mem[rf_read_addr];
  always @(posedge CLK) rf_mem[rf_write_addr] <= rf_write_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: applies one command to ref_mem and predicts the response.
  task automatic model(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d,
                       output logic [3:0] ed, output logic ec, output int el);
    int s;
    el = 2;
    ec = 1'b0;
    case (op)
      OP_READ:  ed = ref_mem[a];
      OP_WRITE: begin ref_mem[a] = d; ed = d; end
      OP_ADD: begin
        s  = int'(ref_mem[a]) + int'(d);
        ed = 4'(s % 16);
        ec = (s > 15);
        ref_mem[a] = ed;
      end
      default: begin
        for (int i = 0; i < 4; i++) ref_mem[i] = 4'd0;
        ed = 4'd0;
        el = 5;
      end
    endcase
  endtask

  task automatic apply_reset(input int cycles);
    RESET = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      chk("rst_busy",   32'(busy), 32'd1);
      chk("rst_ready",  32'(bus.cmd_ready), 32'd0);
      chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
      chk("rst_rdata",  32'(bus.resp_data), 32'd0);
      chk("rst_rcarry", 32'(bus.resp_carry), 32'd0);
    end
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sweep_busy",   32'(busy), 32'd1);
      chk("sweep_ready",  32'(bus.cmd_ready), 32'd0);
      chk("sweep_rvalid", 32'(bus.resp_valid), 32'd0);
      @(posedge CLK); #1;
    end
    chk("post_rst_busy",   32'(busy), 32'd0);
    chk("post_rst_ready",  32'(bus.cmd_ready), 32'd1);
    chk("post_rst_rvalid", 32'(bus.resp_valid), 32'd0);
    for (int i = 0; i < 4; i++) ref_mem[i] = 4'd0;
  endtask

  // Issue one command with resp_ready high; returns response and accept-to-valid latency.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d,
                        output logic [3:0] rd, output logic rc, output int lat);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 50) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("resp_valid_wait", 32'(bus.resp_valid), 32'd1);
    rd = bus.resp_data;
    rc = bus.resp_carry;
    @(posedge CLK); #1;
    chk("resp_drop", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    vec_t       vecs[$];
    logic [3:0] rd, ed;
    logic       rc, ec;
    int         lat, el;
    logic [1:0] op, a;
    logic [3:0] d;
    int         r;

    n_tests = 0;
    n_fail  = 0;
    RESET          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_addr   = 2'd0;
    bus.cmd_data   = 4'd0;
    bus.resp_ready = 1'b1;

    vecs.push_back('{OP_READ,  2'd0, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd1, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd2, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd3, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_WRITE, 2'd2, 4'hA, 4'hA, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd2, 4'd0, 4'hA, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd0, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd1, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd3, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_WRITE, 2'd1, 4'hE, 4'hE, 1'b0, 2});
    vecs.push_back('{OP_ADD,   2'd1, 4'h3, 4'h1, 1'b1, 2});
    vecs.push_back('{OP_READ,  2'd1, 4'd0, 4'h1, 1'b0, 2});
    vecs.push_back('{OP_ADD,   2'd3, 4'hF, 4'hF, 1'b0, 2});
    vecs.push_back('{OP_ADD,   2'd3, 4'h1, 4'h0, 1'b1, 2});
    vecs.push_back('{OP_WRITE, 2'd0, 4'h5, 4'h5, 1'b0, 2});
    vecs.push_back('{OP_WRITE, 2'd1, 4'h6, 4'h6, 1'b0, 2});
    vecs.push_back('{OP_WRITE, 2'd2, 4'h7, 4'h7, 1'b0, 2});
    vecs.push_back('{OP_WRITE, 2'd3, 4'h8, 4'h8, 1'b0, 2});
    vecs.push_back('{OP_CLEAR, 2'd2, 4'h9, 4'h0, 1'b0, 5});
    vecs.push_back('{OP_READ,  2'd0, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd1, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd2, 4'd0, 4'h0, 1'b0, 2});
    vecs.push_back('{OP_READ,  2'd3, 4'd0, 4'h0, 1'b0, 2});

    apply_reset(1);

    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].addr, vecs[i].data, ed, ec, el);
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, rd, rc, lat);
      chk($sformatf("vec%0d_data", i),  32'(rd),  32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_carry", i), 32'(rc),  32'(vecs[i].exp_carry));
      chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
    end

    // Stalled READ with a competing command offered during the stall.
    model(OP_WRITE, 2'd3, 4'h9, ed, ec, el);
    do_cmd(OP_WRITE, 2'd3, 4'h9, rd, rc, lat);
    model(OP_READ, 2'd3, 4'h0, ed, ec, el);
    bus.resp_ready = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = OP_READ;
    bus.cmd_addr   = 2'd3;
    @(posedge CLK); #1;
    bus.cmd_op     = OP_WRITE;
    bus.cmd_data   = 4'h6;
    @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rvalid", 32'(bus.resp_valid), 32'd1);
      chk("stall_rdata",  32'(bus.resp_data), 32'(ed));
      chk("stall_rcarry", 32'(bus.resp_carry), 32'd0);
      chk("stall_ready",  32'(bus.cmd_ready), 32'd0);
      @(posedge CLK); #1;
    end
    bus.cmd_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("stall_release_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("stall_release_ready",  32'(bus.cmd_ready), 32'd1);
    chk("stall_release_busy",   32'(busy), 32'd0);
    model(OP_READ, 2'd3, 4'h0, ed, ec, el);
    do_cmd(OP_READ, 2'd3, 4'h0, rd, rc, lat);
    chk("stall_ignored_write", 32'(rd), 32'(ed));

    // Reset while an ADD response is pending; multi-cycle reset then sweep.
    model(OP_WRITE, 2'd1, 4'hC, ed, ec, el);
    do_cmd(OP_WRITE, 2'd1, 4'hC, rd, rc, lat);
    model(OP_ADD, 2'd1, 4'h5, ed, ec, el);
    bus.resp_ready = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = OP_ADD;
    bus.cmd_addr   = 2'd1;
    bus.cmd_data   = 4'h5;
    @(posedge CLK); #1;
    bus.cmd_valid  = 1'b0;
    @(posedge CLK); #1;
    chk("add_pending_rvalid", 32'(bus.resp_valid), 32'd1);
    chk("add_pending_rdata",  32'(bus.resp_data), 32'(ed));
    chk("add_pending_rcarry", 32'(bus.resp_carry), 32'(ec));
    bus.resp_ready = 1'b1;
    apply_reset(3);
    for (int i = 0; i < 4; i++) begin
      do_cmd(OP_READ, 2'(i), 4'h0, rd, rc, lat);
      chk($sformatf("post_reset_read%0d", i), 32'(rd), 32'd0);
    end

    // Randomized commands against the model.
    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 3) ? OP_READ : (r < 6) ? OP_WRITE : (r < 9) ? OP_ADD : OP_CLEAR;
      a  = 2'($urandom_range(0, 3));
      d  = 4'($urandom_range(0, 15));
      model(op, a, d, ed, ec, el);
      do_cmd(op, a, d, rd, rc, lat);
      chk($sformatf("rand%0d_op%0d_data", i, op),  32'(rd),  32'(ed));
      chk($sformatf("rand%0d_op%0d_carry", i, op), 32'(rc),  32'(ec));
      chk($sformatf("rand%0d_op%0d_lat", i, op),   32'(lat), 32'(el));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
